// File: rtl/scancode_display_ctrl.sv
// scancode_display_ctrl: PS/2 scancode sequencer for the 4-digit display.
// Synchronises scan_valid, buffers accepted bytes in a FIFO and writes four
// hex nibbles per byte (newest on digits 1:0, previous on digits 3:2).
// Optional feature macro: BREAK_FILTER_EN drops 0xF0 and the byte after it.
module scancode_display_ctrl #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  scan_code,
  input  logic                        scan_valid,
  output logic [3:0]                  nibble,
  output logic [1:0]                  buf_sel,
  output logic                        load,
  output logic                        busy,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, WR0, WR1, WR2, WR3} state_t;

  state_t        state_q;
  logic [2:0]    sync_q;
  logic          accept;
  logic          push;
  logic          pop;
  logic          full;
  logic          wr_en;
  logic          drop;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   level_q;
  logic          overflow_q;
  logic [7:0]    head;
  logic [7:0]    cur_q;
  logic [7:0]    prev_q;
  logic [3:0]    nibble_q;
  logic [1:0]    buf_sel_q;
  logic          load_q;
  logic          busy_q;

  // Two-flop synchroniser plus a third flop for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[1:0], scan_valid};
  end

  assign accept = sync_q[1] & ~sync_q[2];

`ifdef BREAK_FILTER_EN
  logic skip_q;
  logic skip_d;

  // Break filter: 0xF0 arms the skip flag, the following byte is discarded.
  always_comb begin
    push   = 1'b0;
    skip_d = skip_q;
    if (accept) begin
      if (skip_q)                  skip_d = 1'b0;
      else if (scan_code == 8'hF0) skip_d = 1'b1;
      else                         push   = 1'b1;
    end
  end

  // Skip flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) skip_q <= 1'b0;
    else       skip_q <= skip_d;
  end
`else
  assign push = accept;
`endif

  // A full FIFO still accepts a push when the head is leaving the same cycle.
  assign pop   = (state_q == IDLE) && (level_q != '0);
  assign full  = (level_q == FULL_LVL);
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;
  assign head  = mem_q[rd_ptr_q];

  // FIFO storage; emptied on reset through the pointers, not the contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= scan_code;
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      if (wr_en && !pop)      level_q <= level_q + 1'b1;
      else if (!wr_en && pop) level_q <= level_q - 1'b1;
      if (drop) overflow_q <= 1'b1;
    end
  end

  // Display write sequencer with registered load/select/nibble outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cur_q     <= '0;
      prev_q    <= '0;
      nibble_q  <= '0;
      buf_sel_q <= '0;
      load_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          load_q <= 1'b0;
          busy_q <= 1'b0;
          if (pop) begin
            prev_q  <= cur_q;
            cur_q   <= head;
            state_q <= WR0;
          end
        end
        WR0: begin
          load_q    <= 1'b1;
          busy_q    <= 1'b1;
          buf_sel_q <= 2'd0;
          nibble_q  <= cur_q[3:0];
          state_q   <= WR1;
        end
        WR1: begin
          load_q    <= 1'b1;
          busy_q    <= 1'b1;
          buf_sel_q <= 2'd1;
          nibble_q  <= cur_q[7:4];
          state_q   <= WR2;
        end
        WR2: begin
          load_q    <= 1'b1;
          busy_q    <= 1'b1;
          buf_sel_q <= 2'd2;
          nibble_q  <= prev_q[3:0];
          state_q   <= WR3;
        end
        WR3: begin
          load_q    <= 1'b1;
          busy_q    <= 1'b1;
          buf_sel_q <= 2'd3;
          nibble_q  <= prev_q[7:4];
          state_q   <= IDLE;
        end
        default: begin
          load_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign nibble     = nibble_q;
  assign buf_sel    = buf_sel_q;
  assign load       = load_q;
  assign busy       = busy_q;
  assign overflow   = overflow_q;
  assign fifo_level = level_q;

endmodule

// File: doc/scancode_display_ctrl.md
# scancode_display_ctrl

Sequencer between the PS/2 keyboard receiver and the 4-digit multiplexed display driver. It synchronises the receiver's scancode/valid pair into the 50 MHz system domain and buffers accepted bytes in a small FIFO. For each accepted byte it writes four hex nibbles into the display buffers through a load/select handshake, so the display shows the newest scancode on digits 1:0 and the previous one on digits 3:2.

## Interface
- FIFO_DEPTH, 4, scancode FIFO entries; power of two, 2..16.
- clk  input  1  50 MHz system clock; all state on rising edge.
- reset  input  1  reset, asynchronous, active-high.
- scan_code  input  8  byte from keyboard receiver; stable while scan_valid high.
- scan_valid  input  1  receiver valid, keyboard-clock domain; treated as asynchronous.
- nibble  output  4  hex digit for the 7-segment converter.
- buf_sel  output  2  destination display buffer for nibble (0 = rightmost).
- load  output  1  one-cycle write strobe per digit to the display driver.
- busy  output  1  high while a 4-digit write sequence is in progress.
- overflow  output  1  sticky; set when a byte is dropped on a full FIFO.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Input sync: scan_valid passes through a 2-flop synchroniser plus a third flop for edge detection. A rising edge (sync2 & ~sync3) produces a one-cycle accept pulse; scan_code is sampled on that same cycle.
- Upstream guarantee: scan_code is stable for at least 4 clk cycles after scan_valid rises.
- Accept path: the accepted byte passes through the break filter (see Configuration) and is then pushed into the FIFO.
- Full FIFO: a push with no simultaneous pop drops the byte and sets overflow.
- Full FIFO with simultaneous pop: the push is accepted; fifo_level is unchanged.
- Registers: cur[7:0] and prev[7:0], both 0 after reset.
- FSM states IDLE, WR0, WR1, WR2, WR3.
  - IDLE: if the FIFO is non-empty, pop the head, prev<=cur, cur<=head, go to WR0. Otherwise stay.
  - WR0: load=1, buf_sel=0, nibble=cur[3:0] -> WR1.
  - WR1: load=1, buf_sel=1, nibble=cur[7:4] -> WR2.
  - WR2: load=1, buf_sel=2, nibble=prev[3:0] -> WR3.
  - WR3: load=1, buf_sel=3, nibble=prev[7:4] -> IDLE.
- busy=1 in WR0..WR3. Pops occur only in IDLE, so back-to-back bytes give sequences separated by one IDLE cycle.
- nibble and buf_sel hold their last values when load=0.
- Reset at any time, including mid-sequence: FSM to IDLE, FIFO emptied, cur/prev/filter flag cleared, synchroniser flops cleared. A partial digit write is abandoned, not completed.

## Timing
- Reset values: nibble=0, buf_sel=0, load=0, busy=0, overflow=0, fifo_level=0.
- All outputs are registered; no combinational path from input to output.
- Latency: scan_valid rise to fifo_level increment is 3–4 clk cycles (synchroniser uncertainty).
- Latency: push to first load high is 2 cycles when the FSM is idle.
- Each sequence is exactly 4 consecutive load cycles with buf_sel 0,1,2,3.
- Throughput: one byte per 5 cycles, far above the PS/2 rate. The FIFO only absorbs bursts that arrive while reset-related stalls or sequences are in progress.
- A scan_valid that stays high produces exactly one accept. A new byte requires scan_valid low for at least 2 clk cycles first.

## Configuration
- BREAK_FILTER_EN defined: byte 0xF0 is not pushed and sets a skip flag. The next accepted byte is also discarded and clears the flag, so only make codes reach the display. The flag is cleared by reset.
- BREAK_FILTER_EN undefined: every accepted byte, including 0xF0, is pushed and displayed.

## Test plan
- Reset, then byte 0x1C (key A) -> 4 loads, buf_sel 0..3, nibble C,1,0,0; busy high exactly 4 cycles; fifo_level returns to 0.
- Bytes 0x1C then 0x32 -> second sequence has nibble 2,3,C,1.
- With BREAK_FILTER_EN, bytes 0x1C, 0xF0, 0x1C, 0x32 -> only two sequences; the last shows 2,3,C,1.
- Without BREAK_FILTER_EN, the same stimulus -> four sequences; the second shows 0,F,C,1.
- Force the FSM stalled (hold reset low, pre-load FIFO_DEPTH+1 accepts within one sequence window via testbench backdoor, or push faster than pops) -> fifo_level saturates at 4; overflow=1 and stays 1 until reset.
- Assert reset during WR1 -> next cycle load=0, busy=0, outputs 0. A following byte 0x45 shows nibble 5,4,0,0 (prev cleared).
